// File: rtl/vm_change_dispenser.sv
// Coin payout unit: queues change codes and drives the 10/5 rs hoppers through an eject/sense handshake.
// Optional vend counter is enabled by defining VM_DISP_VEND_COUNT_EN.
module vm_change_dispenser #(
  parameter int FIFO_DEPTH   = 4,
  parameter int PULSE_CYCLES = 4,
  parameter int TIMEOUT      = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       out,
  input  logic [1:0] change,
  input  logic       empty10,
  input  logic       empty5,
  input  logic       coin_sense,
  output logic       eject10,
  output logic       eject5,
  output logic       busy,
  output logic [5:0] owed,
  output logic       overflow,
  output logic       jam,
  output logic [7:0] vend_count
);
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int PW = $clog2(PULSE_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [PW-1:0] PLAST = PW'(PULSE_CYCLES - 1);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, LOAD, SELECT, PULSE, WAIT, JAM} state_t;

  state_t        state, state_n;
  logic [1:0]    rem, rem_n;
  logic          coin10, coin10_n;
  logic          slat, slat_n;
  logic [PW-1:0] pcnt, pcnt_n;
  logic [TW-1:0] tcnt, tcnt_n;
  logic [5:0]    owed_n;
  logic [6:0]    owed_sum;

  logic [1:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0]   cnt;
  logic          push_req, push_ok, pop, full;
  logic [1:0]    head;

  // a pop in the same cycle frees a slot, so a full queue can still take the push
  assign push_req = (change != 2'd0);
  assign pop      = (state == LOAD);
  assign full     = (cnt == (AW+1)'(FIFO_DEPTH));
  assign push_ok  = push_req && (!full || pop);
  assign head     = mem[rp];
  assign busy     = (state != IDLE) || (cnt != '0);
  assign owed_sum = {1'b0, owed} + {5'b0, rem};

  always_ff @(posedge clk)
    if (push_ok) mem[wp] <= change;

  always_ff @(posedge clk) begin
    if (rst) begin
      wp       <= '0;
      rp       <= '0;
      cnt      <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) wp <= wp + AW'(1);
      if (pop)     rp <= rp + AW'(1);
      case ({push_ok, pop})
        2'b10:   cnt <= cnt + (AW+1)'(1);
        2'b01:   cnt <= cnt - (AW+1)'(1);
        default: cnt <= cnt;
      endcase
      if (push_req && !push_ok) overflow <= 1'b1;
    end
  end

  always_comb begin
    state_n  = state;
    rem_n    = rem;
    coin10_n = coin10;
    slat_n   = slat;
    pcnt_n   = pcnt;
    tcnt_n   = tcnt;
    owed_n   = owed;
    case (state)
      IDLE:   if (cnt != '0) state_n = LOAD;
      LOAD: begin
        rem_n   = head;
        state_n = SELECT;
      end
      SELECT: begin
        pcnt_n = '0;
        slat_n = 1'b0;
        if (rem == 2'd0) state_n = IDLE;
        else if (rem >= 2'd2 && !empty10) begin
          coin10_n = 1'b1;
          state_n  = PULSE;
        end else if (!empty5) begin
          coin10_n = 1'b0;
          state_n  = PULSE;
        end else begin
          owed_n  = owed_sum[6] ? 6'd63 : owed_sum[5:0];
          rem_n   = 2'd0;
          state_n = IDLE;
        end
      end
      PULSE: begin
        if (coin_sense) slat_n = 1'b1;
        if (pcnt == PLAST) begin
          tcnt_n  = '0;
          state_n = WAIT;
        end else pcnt_n = pcnt + PW'(1);
      end
      WAIT: begin
        // a sense that arrived during the pulse counts for this coin
        if (coin_sense || slat) begin
          rem_n   = rem - (coin10 ? 2'd2 : 2'd1);
          slat_n  = 1'b0;
          state_n = SELECT;
        end else if (tcnt == TLAST) state_n = JAM;
        else tcnt_n = tcnt + TW'(1);
      end
      JAM:     state_n = JAM;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      rem     <= 2'd0;
      coin10  <= 1'b0;
      slat    <= 1'b0;
      pcnt    <= '0;
      tcnt    <= '0;
      owed    <= '0;
      jam     <= 1'b0;
      eject10 <= 1'b0;
      eject5  <= 1'b0;
    end else begin
      state   <= state_n;
      rem     <= rem_n;
      coin10  <= coin10_n;
      slat    <= slat_n;
      pcnt    <= pcnt_n;
      tcnt    <= tcnt_n;
      owed    <= owed_n;
      jam     <= jam | (state_n == JAM);
      eject10 <= (state_n == PULSE) &&  coin10_n;
      eject5  <= (state_n == PULSE) && !coin10_n;
    end
  end

`ifdef VM_DISP_VEND_COUNT_EN
  always_ff @(posedge clk) begin
    if (rst)      vend_count <= '0;
    else if (out) vend_count <= vend_count + 8'd1;
  end
`else
  logic unused_out;
  assign unused_out = out;
  assign vend_count = '0;
`endif

endmodule

// File: tb/tb_vm_change_dispenser.sv
// Directed bench for vm_change_dispenser: payout sequences, shortages, jam, overflow, reset, vend counter.
module tb_vm_change_dispenser;
  logic       clk = 1'b0;
  logic       rst, out, empty10, empty5, coin_sense;
  logic [1:0] change;
  logic       eject10, eject5, busy, overflow, jam;
  logic [5:0] owed;
  logic [7:0] vend_count;
  int tests = 0;
  int fails = 0;

  vm_change_dispenser dut (
    .clk(clk), .rst(rst), .out(out), .change(change), .empty10(empty10), .empty5(empty5),
    .coin_sense(coin_sense), .eject10(eject10), .eject5(eject5), .busy(busy), .owed(owed),
    .overflow(overflow), .jam(jam), .vend_count(vend_count)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Called in a SELECT cycle that picks a coin; returns at WAIT entry.
  task automatic pulse_phase(input logic is10, input bit latch, input string tag);
    step();
    for (int i = 0; i < 4; i++) begin
      chk({tag, " eject10"}, {7'd0, eject10}, {7'd0, is10});
      chk({tag, " eject5"},  {7'd0, eject5},  {7'd0, !is10});
      coin_sense = (latch && i == 1);
      step();
    end
    coin_sense = 1'b0;
    chk({tag, " ejects low in wait"}, {6'd0, eject10, eject5}, 8'd0);
  endtask

  // Full coin: pulse then sense k cycles into WAIT; returns in the following SELECT.
  task automatic pay_coin(input logic is10, input int k, input string tag);
    pulse_phase(is10, 1'b0, tag);
    repeat (k - 1) step();
    coin_sense = 1'b1;
    step();
    coin_sense = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " eject10"}, {7'd0, eject10}, 8'd0);
    chk({tag, " eject5"}, {7'd0, eject5}, 8'd0);
    chk({tag, " busy"}, {7'd0, busy}, 8'd0);
    chk({tag, " owed"}, {2'd0, owed}, 8'd0);
    chk({tag, " overflow"}, {7'd0, overflow}, 8'd0);
    chk({tag, " jam"}, {7'd0, jam}, 8'd0);
    chk({tag, " vend_count"}, vend_count, 8'd0);
  endtask

  // Push one request and advance to its SELECT cycle (N+3).
  task automatic request(input logic [1:0] c);
    change = c;
    step();
    change = 2'd0;
    chk("busy after push", {7'd0, busy}, 8'd1);
    step();
    step();
    chk("no eject in select", {6'd0, eject10, eject5}, 8'd0);
  endtask

  initial begin
    rst = 1'b1; out = 1'b0; change = 2'd0;
    empty10 = 1'b0; empty5 = 1'b0; coin_sense = 1'b0;
    step();
    step();
    chk_all_zero("reset");
    rst = 1'b0;
    step();

    // single 10 rs, sense 3 cycles into WAIT
    request(2'd2);
    pay_coin(1'b1, 3, "single");
    chk("single busy in select", {7'd0, busy}, 8'd1);
    step();
    chk("single busy idle", {7'd0, busy}, 8'd0);
    chk("single owed", {2'd0, owed}, 8'd0);

    // 15 rs with 10 rs hopper empty -> three 5 rs coins
    empty10 = 1'b1;
    request(2'd3);
    pay_coin(1'b0, 1, "five a");
    pay_coin(1'b0, 2, "five b");
    pay_coin(1'b0, 1, "five c");
    step();
    chk("five busy idle", {7'd0, busy}, 8'd0);
    chk("five owed", {2'd0, owed}, 8'd0);
    empty10 = 1'b0;

    // hoppers run dry: one 10 rs, then 5 rs owed
    empty5 = 1'b1;
    request(2'd3);
    pay_coin(1'b1, 1, "dry");
    empty10 = 1'b1;
    step();
    chk("dry owed", {2'd0, owed}, 8'd1);
    chk("dry busy", {7'd0, busy}, 8'd0);
    chk("dry ejects", {6'd0, eject10, eject5}, 8'd0);
    empty5 = 1'b0; empty10 = 1'b0;

    // back-to-back 5 then 10, second coin's sense latched during pulse
    change = 2'd1;
    step();
    change = 2'd2;
    step();
    change = 2'd0;
    step();
    pay_coin(1'b0, 1, "b2b first");
    step();
    step();
    step();
    pulse_phase(1'b1, 1'b1, "b2b second");
    step();
    chk("latched sense busy select", {7'd0, busy}, 8'd1);
    step();
    chk("latched sense idle", {7'd0, busy}, 8'd0);
    chk("owed sticky", {2'd0, owed}, 8'd1);

    // jam: no sense after the pulse
    request(2'd1);
    pulse_phase(1'b0, 1'b0, "jam");
    repeat (31) step();
    chk("jam before timeout", {7'd0, jam}, 8'd0);
    step();
    chk("jam at timeout", {7'd0, jam}, 8'd1);
    coin_sense = 1'b1;
    step();
    coin_sense = 1'b0;
    step();
    chk("jam stays", {7'd0, jam}, 8'd1);
    chk("jam ejects low", {6'd0, eject10, eject5}, 8'd0);
    chk("jam busy", {7'd0, busy}, 8'd1);

    // overflow: five pushes into depth-4 queue while jammed
    change = 2'd1;
    repeat (4) step();
    chk("overflow after four", {7'd0, overflow}, 8'd0);
    step();
    change = 2'd0;
    chk("overflow after five", {7'd0, overflow}, 8'd1);
    rst = 1'b1;
    step();
    chk_all_zero("reset after jam");
    rst = 1'b0;

    // vend counter wraps 255 -> 0
    out = 1'b1;
    repeat (3) step();
`ifdef VM_DISP_VEND_COUNT_EN
    chk("vend count 3", vend_count, 8'd3);
`else
    chk("vend count off 3", vend_count, 8'd0);
`endif
    repeat (254) step();
    out = 1'b0;
    step();
`ifdef VM_DISP_VEND_COUNT_EN
    chk("vend count wrap", vend_count, 8'd1);
`else
    chk("vend count off wrap", vend_count, 8'd0);
`endif
    chk("idle after vend", {7'd0, busy}, 8'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
